pc_sequencer: RTL and testbench

- Fetch-stage controller that owns the architectural program counter.
- Arbitrates the next PC between three sources, highest priority first: trap vector, execute-stage redirect (branch/jump), sequential PC+4.
- Drives the instruction-memory request/acknowledge handshake and delivers (pc, instruction) pairs to decode through a one-entry output register with stall backpressure.
- Sits between the instruction memory and the decode stage. It discards in-flight fetches made stale by a redirect or trap.

---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller that owns the program counter.
// Picks the next PC (trap vector > execute redirect > PC+4). Runs the
// instruction-memory req/ack handshake and hands (pc, instr) pairs to decode
// through a one-entry output register that honours stall backpressure.
// Build option: define PC_MISALIGN_TRAP_EN to turn misaligned redirects into
// traps and to expose the one-cycle `misaligned` pulse output.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap_valid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     fetch_instr
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);

    // IDLE: out of reset, no request yet.
    // FETCH: normal fetching from pc.
    // FLUSH: waiting out a stale request whose data will be dropped.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic            fetch_valid_d;
    logic [XLEN-1:0] fetch_pc_d;
    logic [31:0]     fetch_instr_d;

    logic            jump;
    logic [XLEN-1:0] target;

    assign jump = trap_valid || redirect_valid;

`ifdef PC_MISALIGN_TRAP_EN
    logic mis_evt;
    logic misaligned_d;

    // A redirect to a non-word-aligned address is treated exactly like a trap.
    assign mis_evt = redirect_valid && !trap_valid && (redirect_addr[1:0] != 2'b00);
    assign target  = (trap_valid || mis_evt) ? TRAP_VECTOR : redirect_addr;
    // IDLE ignores redirects, so no pulse there either.
    assign misaligned_d = (state_q != ST_IDLE) && mis_evt;
`else
    // The low address bits are dropped, so a redirect always lands on a word.
    logic unused_addr_bits;
    assign unused_addr_bits = |redirect_addr[1:0];
    assign target = trap_valid ? TRAP_VECTOR : {redirect_addr[XLEN-1:2], 2'b00};
`endif

    // Next-state, next-PC, output-register and memory-request logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        fetch_valid_d = fetch_valid;
        fetch_pc_d    = fetch_pc;
        fetch_instr_d = fetch_instr;
        imem_req      = 1'b0;
        imem_addr     = '0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                // Only request when the output register has room after this edge.
                imem_req  = !fetch_valid || !stall;
                imem_addr = pc_q;
                if (jump) begin
                    pc_d          = target;
                    fetch_valid_d = 1'b0;
                    if (imem_req && !imem_ack) begin
                        // Keep presenting the old address until the memory answers it.
                        pending_d = pc_q;
                        state_d   = ST_FLUSH;
                    end
                end else begin
                    if (fetch_valid && !stall) begin
                        fetch_valid_d = 1'b0;
                    end
                    if (imem_req && imem_ack) begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_instr_d = imem_rdata;
                        pc_d          = pc_q + XLEN'(4);
                    end
                end
            end

            ST_FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = pending_q;
                if (jump) begin
                    pc_d          = target;
                    fetch_valid_d = 1'b0;
                end else if (fetch_valid && !stall) begin
                    fetch_valid_d = 1'b0;
                end
                // The acked data belongs to the abandoned path and is dropped.
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_VECTOR;
            pending_q   <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            fetch_valid <= fetch_valid_d;
            fetch_pc    <= fetch_pc_d;
            fetch_instr <= fetch_instr_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // One-cycle flag following a misaligned redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= misaligned_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. A behavioural model
// (PC value, queue of stale requests, one-deep output queue) predicts the
// outputs every cycle; a table and a few hand sequences add fixed expectations.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        trap_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misaligned     (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_3C3C;
    endfunction

    int unsigned ack_lat;
    int unsigned wait_cnt;

    assign imem_ack   = imem_req && (wait_cnt >= ack_lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge reset) begin
        if (reset)                      wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    bit          m_started;
    logic [31:0] m_pc;
    logic [31:0] stale_q[$];
    fetch_t      out_q[$];
    bit          m_mis;

    bit          e_req;
    logic [31:0] e_addr;
    bit          e_fv;

    task automatic model_reset();
        m_started = 0;
        m_pc      = 32'h0;
        m_mis     = 0;
        stale_q.delete();
        out_q.delete();
    endtask

    task automatic model_expect();
        e_fv = (out_q.size() != 0);
        if (!m_started) begin
            e_req  = 0;
            e_addr = 32'h0;
        end else if (stale_q.size() != 0) begin
            e_req  = 1;
            e_addr = stale_q[0];
        end else begin
            e_req  = !e_fv || !stall;
            e_addr = m_pc;
        end
    endtask

    task automatic model_compare();
        model_expect();
        check("req", imem_req, e_req);
        check("addr", imem_addr, e_addr);
        check("fetch_valid", fetch_valid, e_fv);
        if (e_fv) begin
            check("fetch_pc", fetch_pc, out_q[0].pc);
            check("fetch_instr", fetch_instr, out_q[0].instr);
        end
`ifdef PC_MISALIGN_TRAP_EN
        check("misaligned", misaligned, m_mis);
`endif
    endtask

    // Advance the model across one rising edge given this cycle's inputs.
    task automatic model_update(input bit ack);
        bit          jmp;
        bit          mis;
        logic [31:0] tgt;
        if (!m_started) begin
            m_started = 1;
            m_mis     = 0;
            return;
        end
        jmp = trap_valid || redirect_valid;
`ifdef PC_MISALIGN_TRAP_EN
        mis = redirect_valid && !trap_valid && (redirect_addr[1:0] != 2'b00);
        tgt = (trap_valid || mis) ? TRAP_VEC : redirect_addr;
`else
        mis = 0;
        tgt = trap_valid ? TRAP_VEC : (redirect_addr & ~32'h3);
`endif
        m_mis = mis;
        if (stale_q.size() != 0) begin
            if (jmp) begin
                m_pc = tgt;
                out_q.delete();
            end
            if (ack) void'(stale_q.pop_front());
        end else if (jmp) begin
            out_q.delete();
            if (e_req && !ack) stale_q.push_back(m_pc);
            m_pc = tgt;
        end else begin
            if (out_q.size() != 0 && !stall) void'(out_q.pop_front());
            if (e_req && ack) begin
                out_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, check shortly after, then
    // step the model across the coming rising edge.
    task automatic cycle(input bit s, input bit rv, input logic [31:0] ra,
                         input bit tv, input int unsigned lat);
        @(negedge clk);
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        trap_valid     = tv;
        ack_lat        = lat;
        #1;
        model_compare();
        model_update(imem_ack);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        trap_valid     = 1'b0;
        ack_lat        = 0;
        #1;
        check("rst_req", imem_req, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_fetch_valid", fetch_valid, 32'h0);
        check("rst_fetch_pc", fetch_pc, 32'h0);
        check("rst_fetch_instr", fetch_instr, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        check("rst_misaligned", misaligned, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_compare();
        model_update(imem_ack);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          stall;
        bit          req;
        logic [31:0] addr;
        bit          fv;
        logic [31:0] fpc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        trap_valid     = 1'b0;
        ack_lat        = 0;
        model_reset();

        // Streaming at one per cycle, then a 3-cycle stall holding PC 8.
        vecs[0] = '{stall: 0, req: 1, addr: 32'h00, fv: 0, fpc: 32'h0};
        vecs[1] = '{stall: 0, req: 1, addr: 32'h04, fv: 1, fpc: 32'h0};
        vecs[2] = '{stall: 0, req: 1, addr: 32'h08, fv: 1, fpc: 32'h4};
        vecs[3] = '{stall: 1, req: 0, addr: 32'h0C, fv: 1, fpc: 32'h8};
        vecs[4] = '{stall: 1, req: 0, addr: 32'h0C, fv: 1, fpc: 32'h8};
        vecs[5] = '{stall: 1, req: 0, addr: 32'h0C, fv: 1, fpc: 32'h8};
        vecs[6] = '{stall: 0, req: 1, addr: 32'h0C, fv: 1, fpc: 32'h8};
        vecs[7] = '{stall: 0, req: 1, addr: 32'h10, fv: 1, fpc: 32'hC};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].stall, 1'b0, 32'h0, 1'b0, 0);
            check($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("vec%0d_fv", i), fetch_valid, vecs[i].fv);
            if (vecs[i].fv) begin
                check($sformatf("vec%0d_fpc", i), fetch_pc, vecs[i].fpc);
                check($sformatf("vec%0d_instr", i), fetch_instr, mem_word(vecs[i].fpc));
            end
        end

        // Redirect while a slow request to 0x10 is outstanding.
        cycle(0, 1, 32'h10, 0, 0);
        cycle(0, 0, 32'h0, 0, 3);
        check("slow_addr0", imem_addr, 32'h10);
        cycle(0, 1, 32'h200, 0, 3);
        check("slow_addr1", imem_addr, 32'h10);
        cycle(0, 0, 32'h0, 0, 3);
        check("flush_addr", imem_addr, 32'h10);
        check("flush_req", imem_req, 32'h1);
        check("flush_fv", fetch_valid, 32'h0);
        cycle(0, 0, 32'h0, 0, 3);
        check("flush_ack_addr", imem_addr, 32'h10);
        check("flush_ack", imem_ack, 32'h1);
        cycle(0, 0, 32'h0, 0, 0);
        check("post_flush_addr", imem_addr, 32'h200);
        check("post_flush_fv", fetch_valid, 32'h0);
        cycle(0, 0, 32'h0, 0, 0);
        check("post_flush_fpc", fetch_pc, 32'h200);

        // Trap wins over a simultaneous redirect.
        cycle(0, 1, 32'h300, 1, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check("trap_prio_addr", imem_addr, TRAP_VEC);

        // Sequential PC wraps at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 32'h0, 0, 0);
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);

        // Misaligned redirect.
        cycle(0, 1, 32'h202, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check("misalign_addr", imem_addr, TRAP_VEC);
        check("misalign_pulse", misaligned, 32'h1);
        cycle(0, 0, 32'h0, 0, 0);
        check("misalign_pulse_end", misaligned, 32'h0);
`else
        check("misalign_addr", imem_addr, 32'h200);
`endif

        // Reset while a request is outstanding drops it immediately.
        cycle(0, 0, 32'h0, 0, 3);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [31:0] ra;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                r  = $urandom_range(0, 15);
                ra = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
                cycle($urandom_range(0, 3) == 0, (r == 0) || (r == 1), ra, r == 2,
                      $urandom_range(0, 2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
